multi_rate_tick_generator: RTL and testbench
============================================

// Module: multi_rate_tick_generator
// PURPOSE
//  Synchronous replacement for the ripple divider chain. It derives exact-rate,
//  single-cycle tick enables from the 50 MHz board clock: a fast channel for
//  LED-matrix scanning and a slow channel for 1 Hz timekeeping.
//  Also provides a 50%-duty square output per channel and a modulo seconds
//  counter. Downstream logic stays on `clock` and uses the ticks as enables.
//  No derived clocks.
// PARAMETERS
//  FAST_DIV  50_000      fast-channel divisor in clock cycles (1 kHz); must be >= 2
//  SLOW_DIV  50_000_000  slow-channel divisor in clock cycles (1 Hz); must be >= 2
//  SEC_MOD   60          seconds-counter modulus; must be >= 2
//  FW/SW/CW  derived     $clog2(FAST_DIV), $clog2(SLOW_DIV), $clog2(SEC_MOD); localparam
// PORTS
//  clock        in   1   system clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  enable       in   1   1 = counters advance; 0 = all counters hold (pause)
//  restart      in   1   synchronous clear of all counters, ticks and squares
//  fast_tick    out  1   1-cycle pulse every FAST_DIV enabled cycles
//  slow_tick    out  1   1-cycle pulse every SLOW_DIV enabled cycles
//  fast_square  out  1   square wave, period FAST_DIV enabled cycles
//  slow_square  out  1   square wave, period SLOW_DIV enabled cycles
//  sec_count    out  CW  counts slow ticks, 0..SEC_MOD-1, then wraps
//  sec_wrap     out  1   1-cycle pulse when sec_count wraps SEC_MOD-1 -> 0
// BEHAVIOUR
//  - Reset (reset_n = 0): all internal counters and outputs are 0 immediately,
//    independent of clock. This includes mid-count.
//  - All outputs are registered. There is no combinational path from input to output.
//  - Priority on each rising edge: restart > enable > hold.
//  - restart = 1: the fast counter, slow counter and sec_count go to 0. All ticks,
//    squares and sec_wrap go to 0. This holds regardless of enable.
//  - enable = 1, per channel with counter c and divisor D:
//    - If c == D-1: c <= 0 and tick <= 1.
//    - Otherwise: c <= c+1 and tick <= 0.
//    - Update square <= (next c >= D/2), using integer floor.
//  - enable = 0: counters and squares hold; ticks and sec_wrap are forced to 0.
//  - Tick timing: the first tick is high in the cycle after the D-th enabled edge
//    following reset or restart. Ticks then repeat exactly every D enabled cycles.
//  - Square duty: high for ceil(D/2) enabled cycles and low for floor(D/2). Its
//    rising edge is D/2 cycles after the counter wrap.
//  - Channels are independent counters but share restart/enable, so they stay
//    phase-aligned from restart. When D_slow % D_fast == 0, every slow_tick
//    coincides with a fast_tick.
//  - Seconds counter: on the same edge that sets slow_tick, it advances:
//    - If sec_count == SEC_MOD-1: sec_count <= 0 and sec_wrap <= 1.
//    - Otherwise: sec_count <= sec_count+1 and sec_wrap <= 0.
//    - sec_count and slow_tick therefore change in the same cycle.
//  - Counter widths are sized by $clog2. Wrap is by compare, never by natural
//    overflow, so non-power-of-2 divisors are exact.
//  - Any divisor < 2 or SEC_MOD < 2 is an elaboration error (generate-time $error).
// TESTING (bench uses FAST_DIV=4, SLOW_DIV=10, SEC_MOD=3)
//  1. Release reset with enable=1 held. Expect fast_tick high at cycles 4, 8, 12 and
//     slow_tick high at 10, 20. Expect fast_square 0,0,1,1 repeating and slow_square
//     low 5 / high 5 cycles.
//  2. Run 30 enabled cycles. Expect sec_count 1 at cycle 10, 2 at cycle 20, 0 at
//     cycle 30, with sec_wrap high only at cycle 30.
//  3. Drop enable at cycle 6 for 7 cycles, then restore it. Expect no ticks while
//     paused and squares frozen. The next slow_tick arrives at cycle 17.
//  4. Assert restart and enable together at cycle 7. Next cycle, all outputs are 0.
//     The next fast_tick comes 4 cycles and slow_tick 10 cycles after restart.
//  5. Pull reset_n low asynchronously mid-count with sec_count=2. Outputs are 0
//     before the next clock edge. After release, the scenario 1 timing repeats.
//  6. Set SLOW_DIV=7 (odd). Expect slow_square high 4 / low 3 cycles and slow_tick
//     every 7 cycles.

Source files
------------

// File: rtl/multi_rate_tick_generator.sv
// Derives single-cycle tick enables, 50%-duty squares and a modulo seconds count
// from one system clock; downstream logic uses the ticks as enables, never as clocks.
module multi_rate_tick_generator #(
    parameter int FAST_DIV = 50_000,
    parameter int SLOW_DIV = 50_000_000,
    parameter int SEC_MOD  = 60
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       restart,
    output logic                       fast_tick,
    output logic                       slow_tick,
    output logic                       fast_square,
    output logic                       slow_square,
    output logic [$clog2(SEC_MOD)-1:0] sec_count,
    output logic                       sec_wrap
);

    localparam int FW = $clog2(FAST_DIV);
    localparam int SW = $clog2(SLOW_DIV);
    localparam int CW = $clog2(SEC_MOD);

    localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);
    localparam logic [FW-1:0] FAST_HALF = FW'(FAST_DIV / 2);
    localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_DIV - 1);
    localparam logic [SW-1:0] SLOW_HALF = SW'(SLOW_DIV / 2);
    localparam logic [CW-1:0] SEC_LAST  = CW'(SEC_MOD - 1);

    if (FAST_DIV < 2) begin : g_bad_fast_div
        $error("FAST_DIV must be >= 2");
    end
    if (SLOW_DIV < 2) begin : g_bad_slow_div
        $error("SLOW_DIV must be >= 2");
    end
    if (SEC_MOD < 2) begin : g_bad_sec_mod
        $error("SEC_MOD must be >= 2");
    end

    logic [FW-1:0] fast_cnt_q, fast_cnt_d;
    logic [SW-1:0] slow_cnt_q, slow_cnt_d;
    logic [CW-1:0] sec_q, sec_d;
    logic          fast_tick_q, fast_tick_d;
    logic          slow_tick_q, slow_tick_d;
    logic          fast_sq_q, fast_sq_d;
    logic          slow_sq_q, slow_sq_d;
    logic          wrap_q, wrap_d;

    // Priority restart > enable > hold; pulses fall to 0 whenever no wrap happens.
    always_comb begin
        fast_cnt_d  = fast_cnt_q;
        slow_cnt_d  = slow_cnt_q;
        sec_d       = sec_q;
        fast_tick_d = 1'b0;
        slow_tick_d = 1'b0;
        fast_sq_d   = fast_sq_q;
        slow_sq_d   = slow_sq_q;
        wrap_d      = 1'b0;
        if (restart) begin
            fast_cnt_d = '0;
            slow_cnt_d = '0;
            sec_d      = '0;
            fast_sq_d  = 1'b0;
            slow_sq_d  = 1'b0;
        end else if (enable) begin
            if (fast_cnt_q == FAST_LAST) begin
                fast_cnt_d  = '0;
                fast_tick_d = 1'b1;
            end else begin
                fast_cnt_d = fast_cnt_q + FW'(1);
            end
            fast_sq_d = (fast_cnt_d >= FAST_HALF);

            if (slow_cnt_q == SLOW_LAST) begin
                slow_cnt_d  = '0;
                slow_tick_d = 1'b1;
                if (sec_q == SEC_LAST) begin
                    sec_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    sec_d = sec_q + CW'(1);
                end
            end else begin
                slow_cnt_d = slow_cnt_q + SW'(1);
            end
            slow_sq_d = (slow_cnt_d >= SLOW_HALF);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fast_cnt_q  <= '0;
            slow_cnt_q  <= '0;
            sec_q       <= '0;
            fast_tick_q <= 1'b0;
            slow_tick_q <= 1'b0;
            fast_sq_q   <= 1'b0;
            slow_sq_q   <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            fast_cnt_q  <= fast_cnt_d;
            slow_cnt_q  <= slow_cnt_d;
            sec_q       <= sec_d;
            fast_tick_q <= fast_tick_d;
            slow_tick_q <= slow_tick_d;
            fast_sq_q   <= fast_sq_d;
            slow_sq_q   <= slow_sq_d;
            wrap_q      <= wrap_d;
        end
    end

    assign fast_tick   = fast_tick_q;
    assign slow_tick   = slow_tick_q;
    assign fast_square = fast_sq_q;
    assign slow_square = slow_sq_q;
    assign sec_count   = sec_q;
    assign sec_wrap    = wrap_q;

endmodule

// File: tb/tb_multi_rate_tick_generator.sv
// Bench for multi_rate_tick_generator: two instances (even and odd slow divisor)
// checked every cycle against an edge-count model of the tick/square/seconds rules.
module tb_multi_rate_tick_generator;

    localparam int FAST  = 4;
    localparam int SLOW  = 10;
    localparam int SLOW7 = 7;
    localparam int SECM  = 3;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       restart;

    logic       a_fast_tick, a_slow_tick, a_fast_sq, a_slow_sq, a_wrap;
    logic [1:0] a_sec;
    logic       b_fast_tick, b_slow_tick, b_fast_sq, b_slow_sq, b_wrap;
    logic [1:0] b_sec;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: enabled edges since the last clear, and whether the last edge advanced.
    int   n_en    = 0;
    logic last_en = 1'b0;

    multi_rate_tick_generator #(.FAST_DIV(FAST), .SLOW_DIV(SLOW), .SEC_MOD(SECM)) dut_a (
        .clock(clock), .reset_n(reset_n), .enable(enable), .restart(restart),
        .fast_tick(a_fast_tick), .slow_tick(a_slow_tick),
        .fast_square(a_fast_sq), .slow_square(a_slow_sq),
        .sec_count(a_sec), .sec_wrap(a_wrap)
    );

    multi_rate_tick_generator #(.FAST_DIV(FAST), .SLOW_DIV(SLOW7), .SEC_MOD(SECM)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(enable), .restart(restart),
        .fast_tick(b_fast_tick), .slow_tick(b_slow_tick),
        .fast_square(b_fast_sq), .slow_square(b_slow_sq),
        .sec_count(b_sec), .sec_wrap(b_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] e_tick(input int d);
        return (last_en && n_en > 0 && (n_en % d) == 0) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] e_sq(input int d);
        return ((n_en % d) >= (d / 2)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] e_sec(input int d);
        return 32'((n_en / d) % SECM);
    endfunction

    function automatic logic [31:0] e_wrap(input int d);
        return (e_tick(d) == 32'd1 && e_sec(d) == 32'd0) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t edges=%0d)", tag, obs, exp, $time, n_en);
        end
    endtask

    task automatic check_all();
        chk("a_fast_tick", 32'(a_fast_tick), e_tick(FAST));
        chk("a_slow_tick", 32'(a_slow_tick), e_tick(SLOW));
        chk("a_fast_sq",   32'(a_fast_sq),   e_sq(FAST));
        chk("a_slow_sq",   32'(a_slow_sq),   e_sq(SLOW));
        chk("a_sec",       32'(a_sec),       e_sec(SLOW));
        chk("a_wrap",      32'(a_wrap),      e_wrap(SLOW));
        chk("b_fast_tick", 32'(b_fast_tick), e_tick(FAST));
        chk("b_slow_tick", 32'(b_slow_tick), e_tick(SLOW7));
        chk("b_fast_sq",   32'(b_fast_sq),   e_sq(FAST));
        chk("b_slow_sq",   32'(b_slow_sq),   e_sq(SLOW7));
        chk("b_sec",       32'(b_sec),       e_sec(SLOW7));
        chk("b_wrap",      32'(b_wrap),      e_wrap(SLOW7));
    endtask

    // One clock: drive inputs, take the edge, advance the model, check 1 time unit later.
    task automatic step(input logic en, input logic rs);
        enable  = en;
        restart = rs;
        @(posedge clock);
        if (reset_n) begin
            if (rs) begin
                n_en    = 0;
                last_en = 1'b0;
            end else if (en) begin
                n_en++;
                last_en = 1'b1;
            end else begin
                last_en = 1'b0;
            end
        end
        #1 check_all();
    endtask

    // Reset asserted between edges; outputs must clear before any further clock edge.
    task automatic async_reset(input int hold_cycles);
        #2 reset_n = 1'b0;
        n_en    = 0;
        last_en = 1'b0;
        #1 check_all();
        for (int i = 0; i < hold_cycles; i++) step(1'b1, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        restart = 1'b0;
        @(posedge clock);
        #1 check_all();
        step(1'b1, 1'b0);
        reset_n = 1'b1;

        // Free run from reset: tick/square timing and a full seconds wrap at 30.
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b0);
            if (i == 4)  chk("s1_fast_tick_4", 32'(a_fast_tick), 32'd1);
            if (i == 10) chk("s2_sec_10", 32'(a_sec), 32'd1);
            if (i == 20) chk("s2_sec_20", 32'(a_sec), 32'd2);
            if (i == 30) chk("s2_wrap_30", 32'(a_wrap), 32'd1);
        end

        // Pause for 7 cycles after 6 enabled cycles; slow tick lands at cycle 17.
        step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("s3_slow_tick_17", 32'(a_slow_tick), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

        // Restart together with enable mid-count.
        step(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("s4_fast_sq_clear", 32'(a_fast_sq), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("s4_fast_tick_4", 32'(a_fast_tick), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        chk("s4_slow_tick_10", 32'(a_slow_tick), 32'd1);

        // Asynchronous reset with sec_count == 2, then the free-run timing again.
        step(1'b1, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
        chk("s5_sec_before", 32'(a_sec), 32'd2);
        async_reset(2);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);

        // Randomised enable/restart/reset traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                async_reset(int'($urandom_range(1, 3)));
            end else begin
                step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 59) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
